imem_loader: RTL
================

# imem_loader

Instruction-memory responder for the rv32 core's fetch port. It is the memory end of the `imem_addr` → `imem_out` interface the core drives. It accepts a program as a 32-bit word stream over a valid/ready load port, stores it in an internal word array, and holds the core in reset during loading. Once loaded, it answers fetches combinationally, returning a NOP for unloaded, out-of-range or misaligned addresses.

## Interface

Parameters:
- `DEPTH`, 256: number of 32-bit words; must be a power of two, ≥ 4.
- `ADDR_W`, 8: word-index width; must equal log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (0 = reset).
- `ld_valid`  in  1  load word present.
- `ld_data`  in  32  load word.
- `ld_last`  in  1  marks the final program word; qualified by `ld_valid`.
- `ld_ready`  out  1  loader can accept a word (registered).
- `imem_addr`  in  32  byte fetch address from the core.
- `imem_out`  out  32  fetched instruction (combinational from `imem_addr` and state).
- `cpu_rst`  out  1  active-high reset to the core (registered).
- `run`  out  1  program loaded, fetches served (registered).
- `misalign`  out  1  `imem_addr[1:0] != 0` while `run` = 1 (combinational).
- `loaded_words`  out  `ADDR_W`+1  count of words written since reset.

## Operation

- States:
  - LOAD (reset state).
  - RUN.
  - No other states.
- **Reset** (`rst` = 0 at an edge) forces the following, regardless of state:
  - state = LOAD, `ld_ready` = 0, `loaded_words` = 0, write pointer = 0;
  - hold counter = 0, `cpu_rst` = 1, `run` = 0.
  - Array contents are not cleared. They become unreadable because `loaded_words` = 0.
- **LOAD**:
  - `ld_ready` = 1 from the first edge after reset release.
  - Accept = `ld_valid` & `ld_ready`. On accept: mem[wptr] ← `ld_data`, wptr +1, `loaded_words` +1.
  - `ld_valid` = 0 cycles do not advance anything. Data is held by the source until accepted.
  - Go to RUN on the accepting edge if `ld_last` = 1, or if the accepted word was index `DEPTH`-1 (array full). The full case ignores `ld_last`.
- **RUN**:
  - `ld_ready` = 0; further load words stall indefinitely.
  - Only reset leaves RUN.
- **Fetch decode**, with idx = `imem_addr[ADDR_W+1:2]`:
  - `imem_out` = mem[idx] when all of the following hold: state = RUN, `imem_addr[1:0]` = 0, `imem_addr[31:ADDR_W+2]` = 0, and idx < `loaded_words`.
  - Otherwise `imem_out` = 32'h0000_0013 (NOP, `addi x0,x0,0`).
  - In LOAD, `imem_out` is always NOP and `misalign` = 0.
- **Count width**: `loaded_words` reaches `DEPTH` when the array is full and never wraps. The write pointer never wraps because RUN is entered at full.
- **Simultaneous events**:
  - `rst` = 0 together with an accept: reset wins and the word is not counted.
  - A write and a fetch of the same index cannot coincide, because fetches are only served in RUN.

## Timing

- **Load throughput**: one word per cycle at `ld_valid` = 1.
- **Write latency**: a word accepted at edge N is readable from edge N+1, once RUN is reached.
- **LOAD → RUN**, with edge N accepting the last word:
  - After edge N: `run` = 1 and hold = 2.
  - Edge N+1: hold = 1.
  - Edge N+2: hold = 0 and `cpu_rst` falls.
  - `cpu_rst` is therefore 1 for exactly two cycles with `run` = 1. The core sees stable memory before leaving reset.
- **`cpu_rst`** = 1 whenever state = LOAD or hold ≠ 0.
- **Fetch**: zero-cycle combinational read. `imem_out` is valid in the same cycle `imem_addr` changes, as the core expects.
- **Reset mid-load or mid-run**: all outputs take their reset values at that edge. A fresh load then starts at index 0.

## Test plan

- Reset, then load 32'h0ff0_0093, 32'h0000_c193, 32'h0000_0013 (`ld_last` on the third) → `loaded_words` = 3, `run` = 1, `cpu_rst` = 1 for 2 more cycles then 0. `imem_addr` = 0x0 → 0x0ff0_0093; 0x4 → 0x0000_c193.
- After the load above, `imem_addr` = 0xC (idx 3 ≥ `loaded_words`) → 0x0000_0013. `imem_addr` = 0x400 with `DEPTH` = 256 (out of range) → 0x0000_0013, `misalign` = 0.
- After the load above, `imem_addr` = 0x2 → `misalign` = 1, `imem_out` = 0x0000_0013. `imem_addr` = 0x8 → `misalign` = 0, `imem_out` = 0x0000_0013.
- `DEPTH` = 4, stream 5 words (0x11, 0x22, 0x33, 0x44, 0x55) with no `ld_last` → 4 accepted, `ld_ready` = 0 after the 4th, 0x55 never taken, `loaded_words` = 4. `imem_addr` = 0xC → 0x44.
- `ld_valid` toggling 1,0,0,1,1 with `ld_last` on the final word → exactly 3 words written, in order, `loaded_words` = 3. Reads match the stream.
- Load 2 words, assert `rst` = 0 for one cycle, then load 0xAAAA_AAAA with `ld_last` → `loaded_words` = 1. `imem_addr` = 0x0 → 0xAAAA_AAAA; 0x4 → 0x0000_0013. `cpu_rst` stays 1 throughout reset and reload.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory for the rv32 fetch port: loads a program over a valid/ready word
// stream while holding the core in reset, then serves combinational fetches.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       imem_addr,
    output logic [31:0]       imem_out,
    output logic              cpu_rst,
    output logic              run,
    output logic              misalign,
    output logic [ADDR_W:0]   loaded_words
);

    localparam logic [31:0]       NOP      = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic              ld_ready_q, ld_ready_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        hold_q, hold_d;
    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_hit;

    // ld_ready is only ever high in LOAD, so it alone qualifies an accept.
    assign accept = ld_valid & ld_ready_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        hold_d  = hold_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (wptr_q != LAST_IDX) begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (ld_last || (wptr_q == LAST_IDX)) begin
                        state_d = RUN;
                        hold_d  = 2'd2;
                    end
                end
            end
            RUN: begin
                if (hold_q != 2'd0) begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        ld_ready_d = (state_d == LOAD);
        run_d      = (state_d == RUN);
        cpu_rst_d  = (state_d == LOAD) || (hold_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LOAD;
            ld_ready_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            run_q      <= 1'b0;
            wptr_q     <= '0;
            count_q    <= '0;
            hold_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            ld_ready_q <= ld_ready_d;
            cpu_rst_q  <= cpu_rst_d;
            run_q      <= run_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
        end
    end

    // Array contents survive reset; they are hidden by the zeroed word count instead.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            mem_q[wptr_q] <= ld_data;
        end
    end

    assign fetch_idx = imem_addr[ADDR_W+1:2];
    assign fetch_hit = run_q
                     && (imem_addr[1:0] == 2'b00)
                     && (imem_addr[31:ADDR_W+2] == '0)
                     && ({1'b0, fetch_idx} < count_q);

    assign imem_out     = fetch_hit ? mem_q[fetch_idx] : NOP;
    assign misalign     = run_q && (imem_addr[1:0] != 2'b00);
    assign ld_ready     = ld_ready_q;
    assign cpu_rst      = cpu_rst_q;
    assign run          = run_q;
    assign loaded_words = count_q;

endmodule
